phys_reg_free_list: RTL and testbench

- Physical-register allocator for the 2-wide dispatch stage. Hands out destination physical tags to dispatch slots 1 and 2, and reclaims tags released at retire.
- Publishes the free_pool bitmap consumed by the reservation station.
- Circular FIFO of 6-bit tags with all-or-nothing 2-wide allocation and 2-wide free.

---
 rtl/phys_reg_free_list.sv | 173 +++++++++++++++++
 tb/tb_phys_reg_free_list.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/phys_reg_free_list.sv
// phys_reg_free_list: physical-register free list for a 2-wide dispatch stage.
// It keeps a circular FIFO of free physical tags. Both requested tags are
// granted together or neither is. Up to two retired tags are reclaimed per
// cycle. The free_pool bitmap mirrors which tags are currently in the list.
// Optional build macro FREELIST_CHECK_EN adds double-free, duplicate-free and
// overflow detection, reported on a sticky err output.
module phys_reg_free_list #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_AREGS = 32,
    parameter int PTAG_W    = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alloc_req_1,
    input  logic                 alloc_req_2,
    output logic                 alloc_gnt,
    output logic [PTAG_W-1:0]    alloc_tag_1,
    output logic [PTAG_W-1:0]    alloc_tag_2,
    input  logic                 free_vld_1,
    input  logic [PTAG_W-1:0]    free_tag_1,
    input  logic                 free_vld_2,
    input  logic [PTAG_W-1:0]    free_tag_2,
    output logic [NUM_PREGS-1:0] free_pool,
    output logic [PTAG_W:0]      free_count,
`ifdef FREELIST_CHECK_EN
    output logic                 err,
`endif
    output logic                 empty
);

    // The list holds at most NUM_PREGS-1 tags because p0 never enters it.
    localparam logic [PTAG_W:0] MAX_COUNT = (PTAG_W+1)'(NUM_PREGS - 1);

    logic [PTAG_W-1:0]    entry_reg [NUM_PREGS];
    logic [PTAG_W-1:0]    head_reg, head_next;
    logic [PTAG_W-1:0]    tail_reg, tail_next;
    logic [PTAG_W:0]      count_reg, count_next;
    logic [NUM_PREGS-1:0] pool_reg, pool_next, pool_after_alloc;
    logic                 empty_reg, empty_next;

    logic [1:0]           req_n;
    logic [PTAG_W:0]      req_n_ext;
    logic                 gnt;
    logic [PTAG_W-1:0]    head_p1;
    logic [PTAG_W-1:0]    tag_1, tag_2;
    logic [PTAG_W:0]      base_count, base_count_1;
    logic                 want_1, want_2;
    logic                 dbl_1, dbl_2, dup_2;
    logic                 acc_1, acc_2;
    logic [PTAG_W-1:0]    wr_addr_1, wr_addr_2;

    // ---------------- allocation side ----------------
    assign req_n     = {1'b0, alloc_req_1} + {1'b0, alloc_req_2};
    assign req_n_ext = {{(PTAG_W-1){1'b0}}, req_n};
    assign gnt       = (req_n != 2'd0) && (count_reg >= req_n_ext);
    assign head_p1   = head_reg + PTAG_W'(1);
    assign tag_1     = entry_reg[head_reg];
    // Slot 2 takes the second entry only when slot 1 also consumes one.
    assign tag_2     = (alloc_req_1 && alloc_req_2) ? entry_reg[head_p1]
                                                    : entry_reg[head_reg];

    assign alloc_gnt   = gnt;
    assign alloc_tag_1 = tag_1;
    assign alloc_tag_2 = tag_2;

    // Count left after this cycle's pops; frees are checked against it.
    assign base_count = count_reg - (gnt ? req_n_ext : '0);

    // Bitmap after clearing the granted tags, before any frees are merged.
    for (genvar gi = 0; gi < NUM_PREGS; gi++) begin : g_pool_alloc
        assign pool_after_alloc[gi] = pool_reg[gi] &
            ~(gnt && ((alloc_req_1 && (tag_1 == PTAG_W'(gi))) ||
                      (alloc_req_2 && (tag_2 == PTAG_W'(gi)))));
    end

    // ---------------- free side ----------------
    // p0 is the hard-wired zero register and is never reclaimed.
    assign want_1 = free_vld_1 && (free_tag_1 != '0);
    assign want_2 = free_vld_2 && (free_tag_2 != '0);

`ifdef FREELIST_CHECK_EN
    // A tag popped this cycle is out of the list, so freeing it is legal.
    assign dbl_1 = pool_after_alloc[free_tag_1];
    assign dbl_2 = pool_after_alloc[free_tag_2];
    assign dup_2 = want_1 && (free_tag_1 == free_tag_2);
`else
    assign dbl_1 = 1'b0;
    assign dbl_2 = 1'b0;
    assign dup_2 = 1'b0;
`endif

    assign acc_1        = want_1 && !dbl_1 && (base_count != MAX_COUNT);
    assign base_count_1 = base_count + {{PTAG_W{1'b0}}, acc_1};
    assign acc_2        = want_2 && !dup_2 && !dbl_2 && (base_count_1 != MAX_COUNT);

    // Slot 1 is enqueued first; slot 2 lands right behind it.
    assign wr_addr_1 = tail_reg;
    assign wr_addr_2 = tail_reg + PTAG_W'(acc_1);

    // Merge accepted frees last so a tag popped and freed together ends set.
    for (genvar gi = 0; gi < NUM_PREGS; gi++) begin : g_pool_free
        assign pool_next[gi] = pool_after_alloc[gi] |
            (acc_1 && (free_tag_1 == PTAG_W'(gi))) |
            (acc_2 && (free_tag_2 == PTAG_W'(gi)));
    end

    // Next-state for pointers and occupancy.
    always_comb begin
        head_next  = head_reg;
        if (gnt) begin
            head_next = head_reg + PTAG_W'(req_n);
        end
        tail_next  = tail_reg + PTAG_W'(acc_1) + PTAG_W'(acc_2);
        count_next = base_count_1 + {{PTAG_W{1'b0}}, acc_2};
        empty_next = (count_next == '0);
    end

    // Pointer, count and bitmap registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= PTAG_W'(NUM_PREGS - NUM_AREGS);
            count_reg <= (PTAG_W+1)'(NUM_PREGS - NUM_AREGS);
            empty_reg <= ((NUM_PREGS - NUM_AREGS) == 0);
            for (int i = 0; i < NUM_PREGS; i++) begin
                pool_reg[i] <= (i >= NUM_AREGS);
            end
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
            empty_reg <= empty_next;
            pool_reg  <= pool_next;
        end
    end

    // Tag storage: reset preloads the unmapped tags in ascending order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                entry_reg[i] <= (i < NUM_PREGS - NUM_AREGS) ? PTAG_W'(NUM_AREGS + i)
                                                            : PTAG_W'(0);
            end
        end else begin
            if (acc_1) begin
                entry_reg[wr_addr_1] <= free_tag_1;
            end
            if (acc_2) begin
                entry_reg[wr_addr_2] <= free_tag_2;
            end
        end
    end

`ifdef FREELIST_CHECK_EN
    logic err_reg;

    // Sticky error: any requested non-zero free that was dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if ((want_1 && !acc_1) || (want_2 && !acc_2)) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`endif

    assign free_pool  = pool_reg;
    assign free_count = count_reg;
    assign empty      = empty_reg;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Testbench for phys_reg_free_list: a queue-based model of the free list is
// compared against the DUT every cycle, plus directed literal expectations.
module tb_phys_reg_free_list;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r1 = 0, r2 = 0, v1 = 0, v2 = 0;
    logic [5:0]  t1 = 0, t2 = 0;
    logic        alloc_gnt;
    logic [5:0]  alloc_tag_1, alloc_tag_2;
    logic [63:0] free_pool;
    logic [6:0]  free_count;
    logic        empty;
`ifdef FREELIST_CHECK_EN
    logic        err;
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    phys_reg_free_list dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req_1(r1), .alloc_req_2(r2), .alloc_gnt(alloc_gnt),
        .alloc_tag_1(alloc_tag_1), .alloc_tag_2(alloc_tag_2),
        .free_vld_1(v1), .free_tag_1(t1), .free_vld_2(v2), .free_tag_2(t2),
        .free_pool(free_pool), .free_count(free_count),
`ifdef FREELIST_CHECK_EN
        .err(err),
`endif
        .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int        mq[$];
    bit [63:0] mpool;
    bit        merr;

    task automatic model_reset();
        mq.delete();
        for (int k = 32; k < 64; k++) mq.push_back(k);
        mpool = 64'hFFFF_FFFF_0000_0000;
        merr  = 1'b0;
    endtask

    task automatic model_free(input bit vld, input int tag, input bit dup);
        if (!vld || tag == 0) return;
        if (CHECK && (dup || mpool[tag])) begin
            merr = 1'b1;
        end else if (mq.size() >= 63) begin
            if (CHECK) merr = 1'b1;
        end else begin
            mq.push_back(tag);
            mpool[tag] = 1'b1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            int n;
            n = int'(r1) + int'(r2);
            if (n > 0 && mq.size() >= n) begin
                for (int k = 0; k < n; k++) begin
                    mpool[mq[0]] = 1'b0;
                    void'(mq.pop_front());
                end
            end
            model_free(v1, int'(t1), 1'b0);
            model_free(v2, int'(t2), v1 && t1 == t2);
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            int  n;
            bit  g;
            n = int'(r1) + int'(r2);
            g = (n > 0) && (mq.size() >= n);
            chk("gnt", {63'b0, alloc_gnt}, {63'b0, g});
            if (g && r1) chk("tag1", {58'b0, alloc_tag_1}, 64'(mq[0]));
            if (g && r2) chk("tag2", {58'b0, alloc_tag_2}, 64'(r1 ? mq[1] : mq[0]));
            chk("count", {57'b0, free_count}, 64'(mq.size()));
            chk("empty", {63'b0, empty}, {63'b0, mq.size() == 0});
            chk("pool", free_pool, mpool);
`ifdef FREELIST_CHECK_EN
            chk("err", {63'b0, err}, {63'b0, merr});
`endif
        end
    end

    // Apply one cycle of inputs just after the rising edge, then let them settle.
    task automatic cyc(input bit a1, input bit a2, input bit fv1, input int ft1,
                       input bit fv2, input int ft2);
        @(posedge clk);
        #1;
        r1 = a1; r2 = a2; v1 = fv1; t1 = 6'(ft1); v2 = fv2; t2 = 6'(ft2);
        #2;
        $display("t=%0t req=%b%b free1=%b/%0d free2=%b/%0d -> gnt=%b tags=%0d,%0d count=%0d",
                 $time, a1, a2, fv1, ft1, fv2, ft2, alloc_gnt, alloc_tag_1, alloc_tag_2, free_count);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #2;
        chk("rst_count", {57'b0, free_count}, 64'd32);
        chk("rst_pool", free_pool, 64'hFFFF_FFFF_0000_0000);
        chk("rst_empty", {63'b0, empty}, 64'd0);

        // First 2-wide grant
        cyc(1, 1, 0, 0, 0, 0);
        chk("first_gnt", {63'b0, alloc_gnt}, 64'd1);
        chk("first_tag1", {58'b0, alloc_tag_1}, 64'd32);
        chk("first_tag2", {58'b0, alloc_tag_2}, 64'd33);
        cyc(0, 0, 0, 0, 0, 0);
        chk("after_first_count", {57'b0, free_count}, 64'd30);
        chk("after_first_bits", {62'b0, free_pool[33:32]}, 64'd0);

        // Drain the list completely
        for (int i = 0; i < 15; i++) cyc(1, 1, 0, 0, 0, 0);
        chk("last_tag1", {58'b0, alloc_tag_1}, 64'd62);
        chk("last_tag2", {58'b0, alloc_tag_2}, 64'd63);
        cyc(0, 0, 0, 0, 0, 0);
        chk("drained_empty", {63'b0, empty}, 64'd1);
        chk("drained_count", {57'b0, free_count}, 64'd0);
        cyc(1, 1, 0, 0, 0, 0);
        chk("empty_gnt2", {63'b0, alloc_gnt}, 64'd0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("empty_gnt1", {63'b0, alloc_gnt}, 64'd0);

        // One tag freed: 2-wide must fail, 1-wide gets it
        cyc(0, 0, 1, 5, 0, 0);
        cyc(1, 1, 0, 0, 0, 0);
        chk("one_count", {57'b0, free_count}, 64'd1);
        chk("one_gnt2", {63'b0, alloc_gnt}, 64'd0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("one_gnt1", {63'b0, alloc_gnt}, 64'd1);
        chk("one_tag1", {58'b0, alloc_tag_1}, 64'd5);

        // Advance tail to 63 with pairs, then drain again
        for (int i = 0; i < 15; i++) cyc(0, 0, 1, 10 + 2*i, 1, 11 + 2*i);
        for (int i = 0; i < 15; i++) cyc(1, 1, 0, 0, 0, 0);

        // Free 9,7 on empty list: no bypass, then in-order grant across the wrap
        cyc(1, 0, 1, 9, 1, 7);
        chk("nobypass_gnt", {63'b0, alloc_gnt}, 64'd0);
        cyc(1, 1, 0, 0, 0, 0);
        chk("wrap_gnt", {63'b0, alloc_gnt}, 64'd1);
        chk("wrap_tag1", {58'b0, alloc_tag_1}, 64'd9);
        chk("wrap_tag2", {58'b0, alloc_tag_2}, 64'd7);

        // Free of p0 is ignored
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("p0_count", {57'b0, free_count}, 64'd0);
        chk("p0_pool", free_pool, 64'd0);

        // Fill to capacity; a further free is dropped
        for (int i = 0; i < 31; i++) cyc(0, 0, 1, 2*i + 1, 1, 2*i + 2);
        cyc(0, 0, 1, 63, 0, 0);
        cyc(0, 0, 1, 20, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("full_count", {57'b0, free_count}, 64'd63);

        // Allocate and free the same tag in one cycle
        cyc(1, 0, 1, 1, 0, 0);
        chk("same_gnt", {63'b0, alloc_gnt}, 64'd1);
        chk("same_tag1", {58'b0, alloc_tag_1}, 64'd1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("same_count", {57'b0, free_count}, 64'd63);
        chk("same_bit", {63'b0, free_pool[1]}, 64'd1);

        // Asynchronous reset in the middle of a cycle
        cyc(1, 1, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_count", {57'b0, free_count}, 64'd32);
        chk("midrst_pool", free_pool, 64'hFFFF_FFFF_0000_0000);
        r1 = 0; r2 = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;

`ifdef FREELIST_CHECK_EN
        chk("err_clear", {63'b0, err}, 64'd0);
        cyc(0, 0, 1, 40, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("dbl_count", {57'b0, free_count}, 64'd32);
        chk("dbl_err", {63'b0, err}, 64'd1);
        cyc(0, 0, 1, 3, 1, 3);
        cyc(0, 0, 0, 0, 0, 0);
        chk("dup_count", {57'b0, free_count}, 64'd33);
        cyc(0, 0, 0, 0, 0, 0);
        chk("err_sticky", {63'b0, err}, 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("err_reset", {63'b0, err}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
`endif

        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
